// File: rtl/apcpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apcpu_mem_pkg
//  Description : Shared encodings for the APCPU memory access arbiter:
//                FSM states, ALU MemIO request codes and owner encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package apcpu_mem_pkg;

    // Arbiter FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DATA_RD = 3'd2;
    localparam logic [2:0] ST_DATA_WR = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // ALU MemIO request codes (reserved code behaves as idle)
    localparam logic [1:0] MIO_IDLE = 2'b00;
    localparam logic [1:0] MIO_RD   = 2'b01;
    localparam logic [1:0] MIO_WR   = 2'b10;
    localparam logic [1:0] MIO_RSV  = 2'b11;

    // Transaction owner / last-grant encoding
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_ALU   = 1'b1;

    // Timeout counter width, large enough for TIMEOUT up to 65535
    localparam int CNT_W = 16;

    // True in the states that drive a memory strobe
    function automatic logic is_access(input logic [2:0] st);
        return (st == ST_FETCH) || (st == ST_DATA_RD) || (st == ST_DATA_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_timeout_ctr
//  Description : Clearable up-counter with a terminal-count flag. The flag
//                rises in the enabled cycle whose increment reaches TC, so an
//                access that starts with the counter cleared lasts exactly TC
//                cycles before the flag fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr
    import apcpu_mem_pkg::*;
#(
    parameter int unsigned TC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority over counting so a fresh grant always starts at zero
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_arbiter
//  Description : Shares one memory port between instruction fetch and the ALU
//                data path. Round-robin grant in IDLE, strobe until ack or
//                timeout, one-cycle DONE with the owner's valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arbiter
    import apcpu_mem_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic [DATA_W-1:0] FetchData,
    output logic              FetchValid,
    input  logic [1:0]        MemIO,
    input  logic [ADDR_W-1:0] ALUAddr,
    input  logic [DATA_W-1:0] ALUWrData,
    output logic [DATA_W-1:0] ALURdData,
    output logic              ValidMemData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic              MemRd,
    output logic              MemWr,
    input  logic [DATA_W-1:0] MemRdData,
    input  logic              MemAck,
    output logic              BusError,
    output logic              Busy
);

    logic [2:0]        state_q,       state_d;
    logic              owner_q,       owner_d;
    logic              last_grant_q,  last_grant_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic              mem_rd_q,      mem_rd_d;
    logic              mem_wr_q,      mem_wr_d;
    logic [DATA_W-1:0] fetch_data_q,  fetch_data_d;
    logic [DATA_W-1:0] alu_rdata_q,   alu_rdata_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              alu_valid_q,   alu_valid_d;
    logic              bus_err_q,     bus_err_d;
    logic              busy_q,        busy_d;

    logic              w_alu_pend;
    logic              w_grant_alu;
    logic              w_grant_fetch;
    logic              w_ctr_clr;
    logic              w_ctr_en;
    logic              w_tc;

    // Only explicit read/write codes count as an ALU request
    always_comb begin
        case (MemIO)
            MIO_RD, MIO_WR: w_alu_pend = 1'b1;
            MIO_IDLE, MIO_RSV: w_alu_pend = 1'b0;
            default: w_alu_pend = 1'b0;
        endcase
    end

    // ALU wins a tie only if fetch was served last
    assign w_grant_alu   = w_alu_pend && (!FetchReq || (last_grant_q == OWN_FETCH));
    assign w_grant_fetch = FetchReq && !w_grant_alu;

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_data_d  = fetch_data_q;
        alu_rdata_d   = alu_rdata_q;
        fetch_valid_d = 1'b0;
        alu_valid_d   = 1'b0;
        bus_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_alu) begin
                    state_d      = (MemIO == MIO_RD) ? ST_DATA_RD : ST_DATA_WR;
                    owner_d      = OWN_ALU;
                    last_grant_d = OWN_ALU;
                    mem_addr_d   = ALUAddr;
                    mem_wdata_d  = ALUWrData;
                end else if (w_grant_fetch) begin
                    state_d      = ST_FETCH;
                    owner_d      = OWN_FETCH;
                    last_grant_d = OWN_FETCH;
                    mem_addr_d   = FetchAddr;
                end
            end
            ST_FETCH, ST_DATA_RD, ST_DATA_WR: begin
                // Ack beats a coincident timeout; a timed-out read returns zero
                if (MemAck || w_tc) begin
                    state_d   = ST_DONE;
                    bus_err_d = !MemAck;
                    if (owner_q == OWN_FETCH) begin
                        fetch_valid_d = 1'b1;
                        fetch_data_d  = MemAck ? MemRdData : '0;
                    end else begin
                        alu_valid_d = 1'b1;
                        if (state_q == ST_DATA_RD) begin
                            alu_rdata_d = MemAck ? MemRdData : '0;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_rd_d = (state_d == ST_FETCH) || (state_d == ST_DATA_RD);
        mem_wr_d = (state_d == ST_DATA_WR);
        busy_d   = (state_d != ST_IDLE);
    end

    assign w_ctr_clr = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    assign w_ctr_en  = is_access(state_q);

    mem_timeout_ctr #(
        .TC (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_ctr_clr),
        .en_i  (w_ctr_en),
        .tc_o  (w_tc)
    );

    // State and output registers; reset aborts any access without a pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_FETCH;
            last_grant_q  <= OWN_FETCH;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            fetch_data_q  <= '0;
            alu_rdata_q   <= '0;
            fetch_valid_q <= 1'b0;
            alu_valid_q   <= 1'b0;
            bus_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            fetch_data_q  <= fetch_data_d;
            alu_rdata_q   <= alu_rdata_d;
            fetch_valid_q <= fetch_valid_d;
            alu_valid_q   <= alu_valid_d;
            bus_err_q     <= bus_err_d;
            busy_q        <= busy_d;
        end
    end

    assign MemAddr      = mem_addr_q;
    assign MemWrData    = mem_wdata_q;
    assign MemRd        = mem_rd_q;
    assign MemWr        = mem_wr_q;
    assign FetchData    = fetch_data_q;
    assign FetchValid   = fetch_valid_q;
    assign ALURdData    = alu_rdata_q;
    assign ValidMemData = alu_valid_q;
    assign BusError     = bus_err_q;
    assign Busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_arbiter
//  Description : Directed bench for mem_access_arbiter with a reactive
//                memory model and an expected-transaction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int C_TIMEOUT = 8;
    localparam int C_NEVER   = -1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              FetchReq = 1'b0;
    logic [ADDR_W-1:0] FetchAddr = '0;
    logic [DATA_W-1:0] FetchData;
    logic              FetchValid;
    logic [1:0]        MemIO = 2'b00;
    logic [ADDR_W-1:0] ALUAddr = '0;
    logic [DATA_W-1:0] ALUWrData = '0;
    logic [DATA_W-1:0] ALURdData;
    logic              ValidMemData;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWrData;
    logic              MemRd;
    logic              MemWr;
    logic [DATA_W-1:0] MemRdData = '0;
    logic              MemAck = 1'b0;
    logic              BusError;
    logic              Busy;

    mem_access_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .FetchReq     (FetchReq),
        .FetchAddr    (FetchAddr),
        .FetchData    (FetchData),
        .FetchValid   (FetchValid),
        .MemIO        (MemIO),
        .ALUAddr      (ALUAddr),
        .ALUWrData    (ALUWrData),
        .ALURdData    (ALURdData),
        .ValidMemData (ValidMemData),
        .MemAddr      (MemAddr),
        .MemWrData    (MemWrData),
        .MemRd        (MemRd),
        .MemWr        (MemWr),
        .MemRdData    (MemRdData),
        .MemAck       (MemAck),
        .BusError     (BusError),
        .Busy         (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_alu;
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int          n_strobe = 0;
    int          ack_delay = 0;
    logic [31:0] mem_rdata = '0;
    int          cur_len = 0;
    int          last_len = 0;
    logic        prev_strobe = 1'b0;
    logic [31:0] strobe_addr = '0;
    logic [31:0] strobe_wdata = '0;
    logic        strobe_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model and completion monitor, evaluated on the falling edge
    initial begin
        exp_t e;
        logic strobe;
        forever begin
            @(negedge clk);
            strobe = MemRd | MemWr;
            if (strobe && !prev_strobe) begin
                strobe_addr  = MemAddr;
                strobe_wdata = MemWrData;
                strobe_wr    = MemWr;
                cur_len      = 0;
                n_strobe++;
            end
            if (strobe) cur_len++;
            if (!strobe && prev_strobe) last_len = cur_len;
            prev_strobe = strobe;
            MemAck    = strobe && (ack_delay != C_NEVER) && (cur_len > ack_delay);
            MemRdData = mem_rdata;

            if (FetchValid || ValidMemData) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {30'd0, FetchValid, ValidMemData}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_owner", {30'd0, FetchValid, ValidMemData},
                        e.is_alu ? 32'd1 : 32'd2);
                    chk("access_addr", strobe_addr, e.addr);
                    chk("access_is_write", {31'd0, strobe_wr}, {31'd0, e.is_wr});
                    if (e.is_wr) chk("access_wdata", strobe_wdata, e.wdata);
                    if (e.chk_data) chk("rdata", e.is_alu ? ALURdData : FetchData, e.data);
                    chk("bus_error", {31'd0, BusError}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic push(input logic is_alu, input logic is_wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic chk_data,
                        input logic [31:0] data, input logic err);
        exp_t e;
        e.is_alu = is_alu; e.is_wr = is_wr; e.addr = addr; e.wdata = wdata;
        e.chk_data = chk_data; e.data = data; e.err = err;
        exp_q.push_back(e);
    endtask

    // Wait, bounded, for the next completion pulse; returns at negedge+2
    task automatic wait_valid(input int budget);
        int start;
        bit seen;
        start = n_valid;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #2;
            if (n_valid > start) seen = 1'b1;
        end
        if (!seen) chk("wait_valid_expired", 32'd0, 32'd1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #2;
        end
    endtask

    initial begin
        int   strobes0;
        int   valid0;
        logic busy_any;
        bit   seen;

        // Reset values
        rst = 1'b1;
        step(2);
        chk("rst_busy",   {31'd0, Busy}, 32'd0);
        chk("rst_strobe", {30'd0, MemRd, MemWr}, 32'd0);
        chk("rst_pulses", {29'd0, FetchValid, ValidMemData, BusError}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwrdata", MemWrData, 32'd0);
        chk("rst_fetchdata", FetchData, 32'd0);
        chk("rst_alurddata", ALURdData, 32'd0);
        rst = 1'b0;
        step(1);

        // Both requesters held: ALU first after reset, then alternate
        ack_delay = 0;
        mem_rdata = 32'h1234_5678;
        FetchAddr = 32'h40;
        ALUAddr   = 32'h80;
        push(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        push(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        push(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        push(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        FetchReq = 1'b1;
        MemIO    = 2'b01;
        for (int t = 0; t < 4; t++) wait_valid(20);
        FetchReq = 1'b0;
        MemIO    = 2'b00;
        step(1);

        // Fetch only, ack one cycle after the strobe rises
        ack_delay = 1;
        mem_rdata = 32'hDEAD_BEEF;
        FetchAddr = 32'h100;
        push(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        FetchReq = 1'b1;
        wait_valid(20);
        FetchReq = 1'b0;
        chk("fetch_strobe_len", last_len, 32'd2);
        step(1);
        chk("fetch_busy_after", {31'd0, Busy}, 32'd0);
        chk("fetch_data_hold", FetchData, 32'hDEAD_BEEF);

        // ALU write with immediate ack
        ack_delay = 0;
        ALUAddr   = 32'h20;
        ALUWrData = 32'd28;
        push(1'b1, 1'b1, 32'h20, 32'd28, 1'b0, 32'h0, 1'b0);
        MemIO = 2'b10;
        wait_valid(20);
        MemIO = 2'b00;
        chk("write_strobe_len", last_len, 32'd1);
        step(1);

        // ALU read never acknowledged: timeout after exactly TIMEOUT cycles
        ack_delay = C_NEVER;
        ALUAddr   = 32'h44;
        push(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'h0, 1'b1);
        MemIO = 2'b01;
        wait_valid(40);
        MemIO = 2'b00;
        chk("timeout_strobe_len", last_len, C_TIMEOUT);
        step(1);

        // Reserved MemIO code with no fetch is not a request
        strobes0 = n_strobe;
        busy_any = 1'b0;
        MemIO    = 2'b11;
        for (int i = 0; i < 10; i++) begin
            step(1);
            busy_any = busy_any | Busy;
        end
        MemIO = 2'b00;
        chk("reserved_no_strobe", n_strobe - strobes0, 32'd0);
        chk("reserved_busy", {31'd0, busy_any}, 32'd0);

        // Reset two cycles into a waiting read
        ack_delay = C_NEVER;
        ALUAddr   = 32'h60;
        valid0    = n_valid;
        MemIO     = 2'b01;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            if (MemRd) seen = 1'b1;
        end
        chk("rst_mid_strobe_seen", {31'd0, seen}, 32'd1);
        step(1);
        MemIO = 2'b00;
        rst   = 1'b1;
        #1;
        chk("rst_mid_memrd_async", {31'd0, MemRd}, 32'd0);
        chk("rst_mid_busy_async", {31'd0, Busy}, 32'd0);
        step(2);
        rst = 1'b0;
        step(2);
        chk("rst_mid_no_valid", n_valid - valid0, 32'd0);

        // Fresh fetch after reset completes normally
        ack_delay = 0;
        mem_rdata = 32'hCAFE_F00D;
        FetchAddr = 32'h200;
        push(1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
        FetchReq = 1'b1;
        wait_valid(20);
        FetchReq = 1'b0;
        step(1);

        // After reset the tie-break favours the ALU again
        mem_rdata = 32'h0BAD_CAFE;
        ALUAddr   = 32'h300;
        FetchAddr = 32'h204;
        push(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0BAD_CAFE, 1'b0);
        push(1'b0, 1'b0, 32'h204, 32'h0, 1'b1, 32'h0BAD_CAFE, 1'b0);
        FetchReq = 1'b1;
        MemIO    = 2'b01;
        wait_valid(20);
        wait_valid(20);
        FetchReq = 1'b0;
        MemIO    = 2'b00;
        step(3);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
